// File: rtl/legv8_dmem_responder.sv
// legv8_dmem_responder: handshaked multi-cycle data memory
// serving the LEGv8 core's LDUR/STUR port.
module legv8_dmem_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        CONTROL_MEMREAD,
  input  logic        CONTROL_MEMWRITE,
  input  logic [63:0] ADDRESS,
  input  logic [63:0] WRITE_DATA,
  output logic        RESP_VALID,
  input  logic        RESP_READY,
  output logic [63:0] READ_DATA,
  output logic        RESP_ERROR
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;

  logic        rd_q;
  logic        wr_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;

  logic [63:0] mem [DEPTH];

  logic        accept;
  logic        do_acc;
  logic        acc_rd;
  logic        acc_wr;
  logic        acc_ok;
  logic [63:0] acc_addr;
  logic [63:0] acc_wdata;
  logic [AW-1:0] acc_idx;

  function automatic logic [63:0] init_val(input int i);
    logic [63:0] v;
    v = 64'(i) * 64'd100;
    if (i == 10) v = 64'd1540;
    if (i == 11) v = 64'd2117;
    return v;
  endfunction

  assign REQ_READY = (state_q == S_IDLE) && !RESET;
  assign accept    = REQ_VALID && REQ_READY;

  // With no wait states the access happens on the
  // accepting edge, so the live request is used.
  always_comb begin
    acc_rd    = rd_q;
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      acc_rd    = CONTROL_MEMREAD;
      acc_wr    = CONTROL_MEMWRITE;
      acc_addr  = ADDRESS;
      acc_wdata = WRITE_DATA;
    end
  end

  assign acc_ok  = (acc_rd ^ acc_wr)
                && (acc_addr < 64'(DEPTH));
  assign acc_idx = acc_addr[AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    do_acc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            do_acc  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          do_acc  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (RESP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      rd_q    <= CONTROL_MEMREAD;
      wr_q    <= CONTROL_MEMWRITE;
      addr_q  <= ADDRESS;
      wdata_q <= WRITE_DATA;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      RESP_VALID <= 1'b0;
      READ_DATA  <= '0;
      RESP_ERROR <= 1'b0;
    end else begin
      RESP_VALID <= (state_d == S_RESP);
      if (do_acc) begin
        RESP_ERROR <= !acc_ok;
        READ_DATA  <= '0;
        if (acc_ok && acc_rd) READ_DATA <= mem[acc_idx];
      end
    end
  end

  // Reset restores the preloaded image, so stores die with it.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (do_acc && acc_ok && acc_wr) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_legv8_dmem_responder.sv
// tb_legv8_dmem_responder: directed and random checks of the
// responder at 2, 0 and 5 wait states against a memory model.
module tb_legv8_dmem_responder;

  localparam int WC [3] = '{2, 0, 5};

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        rd         [3];
  logic        wr         [3];
  logic [63:0] address    [3];
  logic [63:0] wdata      [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [63:0] rdata      [3];
  logic        resp_error [3];

  logic [63:0] mdl [3][32];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  legv8_dmem_responder #(.DEPTH(32), .WAIT_CYCLES(2)) dut0 (
    .CLOCK(clk), .RESET(rst),
    .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
    .CONTROL_MEMREAD(rd[0]), .CONTROL_MEMWRITE(wr[0]),
    .ADDRESS(address[0]), .WRITE_DATA(wdata[0]),
    .RESP_VALID(resp_valid[0]), .RESP_READY(resp_ready[0]),
    .READ_DATA(rdata[0]), .RESP_ERROR(resp_error[0])
  );

  legv8_dmem_responder #(.DEPTH(32), .WAIT_CYCLES(0)) dut1 (
    .CLOCK(clk), .RESET(rst),
    .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
    .CONTROL_MEMREAD(rd[1]), .CONTROL_MEMWRITE(wr[1]),
    .ADDRESS(address[1]), .WRITE_DATA(wdata[1]),
    .RESP_VALID(resp_valid[1]), .RESP_READY(resp_ready[1]),
    .READ_DATA(rdata[1]), .RESP_ERROR(resp_error[1])
  );

  legv8_dmem_responder #(.DEPTH(32), .WAIT_CYCLES(5)) dut2 (
    .CLOCK(clk), .RESET(rst),
    .REQ_VALID(req_valid[2]), .REQ_READY(req_ready[2]),
    .CONTROL_MEMREAD(rd[2]), .CONTROL_MEMWRITE(wr[2]),
    .ADDRESS(address[2]), .WRITE_DATA(wdata[2]),
    .RESP_VALID(resp_valid[2]), .RESP_READY(resp_ready[2]),
    .READ_DATA(rdata[2]), .RESP_ERROR(resp_error[2])
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++) mdl[k][i] = 64'(i * 100);
      mdl[k][10] = 64'd1540;
      mdl[k][11] = 64'd2117;
    end
  endtask

  // One full transaction; called and returns on a negedge.
  task automatic xact(input int k, input logic r, input logic w,
                      input logic [63:0] a, input logic [63:0] d,
                      input int hold);
    int n;
    logic ok;
    logic [63:0] ed;
    n = 0;
    while (!req_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 64'(req_ready[k]), 64'd1);
    rd[k] = r;
    wr[k] = w;
    address[k] = a;
    wdata[k] = d;
    resp_ready[k] = (hold == 0);
    req_valid[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    check("ready_drop", 64'(req_ready[k]), 64'd0);
    n = 0;
    while (!resp_valid[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(WC[k]));
    ok = (r != w) && (a < 64'd32);
    ed = 64'd0;
    if (ok && r) ed = mdl[k][a[4:0]];
    if (ok && w) mdl[k][a[4:0]] = d;
    check("read_data", rdata[k], ed);
    check("resp_error", 64'(resp_error[k]), 64'(!ok));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(resp_valid[k]), 64'd1);
      check("bp_data", rdata[k], ed);
      check("bp_error", 64'(resp_error[k]), 64'(!ok));
      check("bp_req_ready", 64'(req_ready[k]), 64'd0);
    end
    resp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hs_valid_clear", 64'(resp_valid[k]), 64'd0);
    check("hs_req_ready", 64'(req_ready[k]), 64'd1);
  endtask

  task automatic thru(input int k);
    int acc[$];
    int p;
    p = WC[k] + 2;
    resp_ready[k] = 1'b1;
    rd[k] = 1'b1;
    wr[k] = 1'b0;
    address[k] = 64'd10;
    req_valid[k] = 1'b1;
    for (int i = 0; i < 4 * p; i++) begin
      if (req_ready[k]) acc.push_back(cyc);
      @(negedge clk);
    end
    req_valid[k] = 1'b0;
    check("thru_count", 64'(acc.size()), 64'd4);
    for (int i = 1; i < acc.size(); i++)
      check("thru_period", 64'(acc[i] - acc[i-1]), 64'(p));
    repeat (p + 2) @(negedge clk);
    check("thru_drain_ready", 64'(req_ready[k]), 64'd1);
    check("thru_drain_valid", 64'(resp_valid[k]), 64'd0);
  endtask

  initial begin
    int op;
    int hold;
    logic [63:0] a;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      rd[k] = 1'b0;
      wr[k] = 1'b0;
      address[k] = '0;
      wdata[k] = '0;
      resp_ready[k] = 1'b1;
    end
    model_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_resp_valid", 64'(resp_valid[k]), 64'd0);
      check("rst_read_data", rdata[k], 64'd0);
      check("rst_resp_error", 64'(resp_error[k]), 64'd0);
      check("rst_req_ready", 64'(req_ready[k]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      check("post_rst_ready", 64'(req_ready[k]), 64'd1);

    xact(0, 1, 0, 64'd10, 64'd0, 0);
    xact(0, 0, 1, 64'd3, 64'hDEAD_BEEF, 0);
    xact(0, 1, 0, 64'd3, 64'd0, 0);
    xact(0, 1, 0, 64'd4, 64'd0, 0);
    xact(0, 1, 0, 64'd32, 64'd0, 0);
    xact(0, 0, 1, 64'h1_0000_0005, 64'd9, 0);
    xact(0, 1, 0, 64'd5, 64'd0, 0);
    xact(0, 1, 1, 64'd2, 64'd1, 0);
    xact(0, 0, 0, 64'd2, 64'd1, 0);
    xact(0, 1, 0, 64'd2, 64'd0, 0);
    xact(0, 1, 0, 64'd11, 64'd0, 5);
    check("directed_3", mdl[0][3], 64'hDEAD_BEEF);

    // reset while a store is still waiting
    rd[0] = 1'b0;
    wr[0] = 1'b1;
    address[0] = 64'd0;
    wdata[0] = 64'd77;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 64'(resp_valid[0]), 64'd0);
    check("midrst_ready", 64'(req_ready[0]), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_resp", 64'(resp_valid[0]), 64'd0);
    end
    xact(0, 1, 0, 64'd0, 64'd0, 0);

    xact(1, 1, 0, 64'd10, 64'd0, 0);
    xact(2, 1, 0, 64'd10, 64'd0, 0);
    xact(1, 0, 1, 64'd7, 64'h1234, 2);
    xact(1, 1, 0, 64'd7, 64'd0, 0);
    xact(2, 1, 0, 64'd31, 64'd0, 1);

    for (int k = 0; k < 3; k++) thru(k);

    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 30; t++) begin
        op = $urandom_range(0, 9);
        hold = $urandom_range(0, 3);
        case ($urandom_range(0, 9))
          0: a = 64'(32 + $urandom_range(0, 100));
          1: a = {32'($urandom), 32'($urandom)};
          default: a = 64'($urandom_range(0, 31));
        endcase
        xact(k, (op < 4) || (op == 8),
             (op >= 4 && op < 8) || (op == 8),
             a, {32'($urandom), 32'($urandom)}, hold);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/legv8_dmem_responder.md
Name: legv8_dmem_responder

Overview:
- Memory-side responder for the CPU's data port: services the load (LDUR) and store (STUR) requests the CPU issues through CONTROL_MEMREAD / CONTROL_MEMWRITE.
- Replaces the zero-latency data memory with a multi-cycle, handshaked model holding 64-bit doublewords, with a programmable wait-state count.
- Lets the CPU and the testbench exercise stalls, back-pressure and access errors.

Parameters:
- DEPTH, 32, number of 64-bit doubleword entries. ADDRESS is a doubleword index.
- WAIT_CYCLES, 2, clock edges from request acceptance to response (0..15).

Ports:
- CLOCK  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  responder can accept a request.
- CONTROL_MEMREAD  in  1  request is a load. Sampled with the request.
- CONTROL_MEMWRITE  in  1  request is a store. Sampled with the request.
- ADDRESS  in  64  doubleword index (the ALU result).
- WRITE_DATA  in  64  store data.
- RESP_VALID  out  1  response present.
- RESP_READY  in  1  requester accepts the response.
- READ_DATA  out  64  load data.
- RESP_ERROR  out  1  request was not executed.

Behaviour:
- Reset (asynchronous, whole block):
  - State goes to IDLE; the counter is cleared.
  - RESP_VALID=0, RESP_ERROR=0, READ_DATA=0.
  - REQ_READY=0 while RESET is high; REQ_READY=1 from the first cycle after release.
  - Memory is reinitialised to Data[i]=i*100 for every i, then Data[10]=1540 and Data[11]=2117.
- FSM states: IDLE, WAIT, RESP. REQ_READY = (state==IDLE) && !RESET.
- IDLE:
  - A request is accepted on a rising edge where REQ_VALID && REQ_READY. Accepting it latches the op bits, ADDRESS and WRITE_DATA.
  - If WAIT_CYCLES==0, the access is performed on that same edge and the state goes to RESP.
  - Otherwise the counter loads WAIT_CYCLES and the state goes to WAIT.
- WAIT:
  - On each edge: if counter==1, perform the access and go to RESP; otherwise decrement the counter.
  - Request inputs are ignored in WAIT.
- Access rules:
  - Valid: exactly one of the latched MEMREAD/MEMWRITE is 1, and latched ADDRESS < DEPTH (the full 64 bits are compared; no truncation or wrap).
  - Valid load: READ_DATA <= Data[ADDRESS].
  - Valid store: Data[ADDRESS] <= latched WRITE_DATA, and READ_DATA <= 0.
  - Invalid (both ops set, neither set, or address out of range): no memory change, READ_DATA <= 0, RESP_ERROR <= 1. Otherwise RESP_ERROR <= 0.
- Latency: RESP_VALID is high in the cycle following edge E+WAIT_CYCLES, where E is the accepting edge.
- RESP:
  - RESP_VALID=1. READ_DATA and RESP_ERROR are held stable until the handshake completes.
  - On an edge with RESP_READY=1: RESP_VALID clears and the state goes to IDLE.
  - A new request can therefore be accepted no sooner than one cycle after the response handshake. At most one request is outstanding.
- RESP_READY may be held high permanently. RESP_READY is ignored outside RESP.
- Store followed by load to the same address: the load returns the new data (the store has completed before the next acceptance).
- Reset mid-operation (WAIT or RESP):
  - The pending request is discarded and no response is produced.
  - A store still in WAIT never writes.
  - A store already performed is lost, because memory is reinitialised.
- All outputs are registered except REQ_READY, which is decoded from state and RESET. No combinational path from inputs to outputs.

Test Plan:
- Load, default params: reset, then request MEMREAD=1, ADDRESS=10. REQ_READY drops the cycle after acceptance; RESP_VALID rises 2 edges after acceptance with READ_DATA=1540 and RESP_ERROR=0.
- Store then load: store WRITE_DATA=64'hDEAD_BEEF to ADDRESS=3 gives a response with READ_DATA=0, RESP_ERROR=0. A following load of ADDRESS=3 returns 64'hDEAD_BEEF; a load of ADDRESS=4 returns 400.
- Errors:
  - Load at ADDRESS=32 gives RESP_ERROR=1 and READ_DATA=0.
  - Store at 64'h1_0000_0005 gives RESP_ERROR=1, and a later load of ADDRESS=5 still returns 500.
  - MEMREAD=MEMWRITE=1 at ADDRESS=2 gives RESP_ERROR=1 with Data[2] unchanged (200).
- Back-pressure: load ADDRESS=11 with RESP_READY=0 for 5 cycles. RESP_VALID, READ_DATA=2117 and REQ_READY=0 stay constant; after RESP_READY=1 for one edge, RESP_VALID=0 and REQ_READY=1.
- Reset mid-WAIT: store 77 to ADDRESS=0, then assert RESET asynchronously (between edges) one cycle after acceptance. RESP_VALID=0 immediately and no response follows; after release, a load of ADDRESS=0 returns 0.
- WAIT_CYCLES=0 and WAIT_CYCLES=5 builds: a load of ADDRESS=10 gives RESP_VALID after the accepting edge and 5 edges after acceptance respectively. Back-to-back loads with RESP_READY tied high are accepted every 2 and 7 cycles respectively.
